rob_queue: RTL and testbench
============================

# rob_queue

Parametrised in-order reorder buffer for the out-of-order core.
- Allocates one entry per cycle from decode and accepts results from two writeback ports (ALU and memory) by tag.
- Retires entries strictly in program order, with a store-commit handshake to the load/store unit.
- On a taken branch or a jump, flushes the whole buffer and emits a redirect PC.
- Sits between decode/rename and the register file, the LSU and the fetch PC logic.

## Interface
- DEPTH, 8, number of entries; power of two, ≥2
- TAG_W, 3, entry tag width; equals log2(DEPTH)
- XLEN, 32, data/PC width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alloc_valid  in  1  decode presents an instruction
- alloc_ready  out  1  entry available this cycle
- alloc_kind  in  2  00 reg-write, 01 store, 10 branch, 11 jump
- alloc_rd  in  5  destination register; 0 means none
- alloc_pc  in  XLEN  instruction PC
- alloc_tag  out  TAG_W  tag that will be assigned (current tail)
- wb0_valid / wb0_tag / wb0_value  in  1/TAG_W/XLEN  ALU result, or store address-ready
- wb1_valid / wb1_tag / wb1_value  in  1/TAG_W/XLEN  load result
- br_valid / br_tag / br_taken / br_target  in  1/TAG_W/1/XLEN  branch or jump resolution
- q_tag  in  TAG_W  operand query tag
- q_ready / q_value  out  1/XLEN  query result
- commit_valid  out  1  one-cycle retire pulse
- commit_rd / commit_value / commit_tag  out  5/XLEN/TAG_W  retire data
- st_commit_valid / st_commit_tag  out  1/TAG_W  store release pulse to LSU
- st_done  in  1  LSU has performed the released store
- flush / flush_pc  out  1/XLEN  redirect pulse and target
- count  out  TAG_W+1  occupied entries

## Operation
- Per-entry state: busy, ready, kind, rd, pc, value, taken, target. Pointers head and tail are TAG_W bits and wrap naturally. count tracks occupancy; full is count==DEPTH, empty is count==0.
- Allocation:
  - Occurs on alloc_valid&alloc_ready. Writes tail; sets busy=1 and ready=0; tail+1.
  - alloc_ready = !full && !(head is busy, ready, and redirecting) && state==RUN.
- Writeback:
  - A wb0 or wb1 hit on a busy entry sets value and ready=1. A hit on a non-busy tag is ignored.
  - wb0 and wb1 hitting the same tag in the same cycle: wb1 wins.
  - br on a busy entry sets taken, target and ready=1. A jump with a destination register keeps value = pc+4.
- Commit FSM, states RUN and ST_WAIT:
  - RUN, head busy&ready, kind reg-write: commit_valid=1, commit_rd=rd, commit_value=value; retire.
  - RUN, head branch: commit_valid=1, commit_rd=0. If taken: flush=1, flush_pc=target.
  - RUN, head jump: commit_valid=1, commit_rd=rd, commit_value=pc+4; flush=1, flush_pc=target.
  - RUN, head store: st_commit_valid=1, st_commit_tag=head; go to ST_WAIT with no retire.
  - ST_WAIT: hold until st_done, then commit_valid=1 with rd=0, retire head, return to RUN. st_done in RUN is ignored.
- Retire: clear busy, head+1, count-1. Simultaneous allocate and retire leaves count unchanged.
- Flush: at the retiring edge, clear all busy bits and set head=tail=count=0. Pending wb/br in that cycle are discarded.
- Query: q_ready = busy[q_tag]&ready[q_tag]; q_value = value[q_tag]. Combinational from registered state.

## Timing
- All outputs except alloc_ready, alloc_tag, q_ready and q_value are registered.
- Reset values: all outputs 0, alloc_ready=1, FSM=RUN, all busy=0.
- Reset asserted in ST_WAIT aborts the store handshake; the LSU is reset by the same rst.
- Writeback at edge k → entry ready at k → commit_valid high in the cycle after edge k+1.
- Maximum one retire per cycle. Back-to-back ready entries retire on consecutive cycles.
- st_commit_valid pulses one cycle. The retire pulse follows the cycle after st_done is sampled.
- flush is high for exactly one cycle, coincident with commit_valid of the redirecting entry. alloc_ready is 1 in the following cycle.

## Configuration
- ROB_BYPASS_EN defined: q_ready/q_value also forward a same-cycle wb0/wb1 hit on q_tag, with wb1 having priority.
- ROB_BYPASS_EN undefined: the query sees registered state only, giving a one-cycle forwarding bubble.

## Test plan
- Fill: 8 allocations with no writeback → alloc_ready=0 and count=8. Writeback tags 0..7, then 8 commit pulses in order; count returns to 0 and tail wraps to 0.
- Out-of-order writeback: allocate 3 reg-writes rd=1,2,3, writeback tags 2,1,0 with values 0x30,0x20,0x10 → commits in order rd1=0x10, rd2=0x20, rd3=0x30.
- Store: allocate a store as tag 0, wb0 tag 0 → st_commit_valid with tag 0. Hold st_done low 5 cycles → no retire. Raise st_done → commit_valid, rd=0.
- Mispredict: allocate branch tag 0 plus 3 reg-writes, br taken target 0x100 → flush=1 and flush_pc=0x100. count=0, and the following writebacks are ignored.
- Jump: pc=0x40, rd=1, target 0x80 → commit_value=0x44 and flush_pc=0x80.
- Bypass: wb0 tag 2 value 0x55 with q_tag=2 in the same cycle → q_ready=1 only with ROB_BYPASS_EN defined, and q_ready=1 next cycle without it.

Source files
------------

// File: rtl/rob_queue.sv
// rob_queue: in-order reorder buffer with ALU/load writeback ports, a store-commit handshake and a
// whole-buffer flush on redirect. Define ROB_BYPASS_EN to forward same-cycle writebacks to the query.
module rob_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TAG_W = 3,
    parameter int unsigned XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [1:0]       alloc_kind,
    input  logic [4:0]       alloc_rd,
    input  logic [XLEN-1:0]  alloc_pc,
    output logic [TAG_W-1:0] alloc_tag,

    input  logic             wb0_valid,
    input  logic [TAG_W-1:0] wb0_tag,
    input  logic [XLEN-1:0]  wb0_value,
    input  logic             wb1_valid,
    input  logic [TAG_W-1:0] wb1_tag,
    input  logic [XLEN-1:0]  wb1_value,

    input  logic             br_valid,
    input  logic [TAG_W-1:0] br_tag,
    input  logic             br_taken,
    input  logic [XLEN-1:0]  br_target,

    input  logic [TAG_W-1:0] q_tag,
    output logic             q_ready,
    output logic [XLEN-1:0]  q_value,

    output logic             commit_valid,
    output logic [4:0]       commit_rd,
    output logic [XLEN-1:0]  commit_value,
    output logic [TAG_W-1:0] commit_tag,

    output logic             st_commit_valid,
    output logic [TAG_W-1:0] st_commit_tag,
    input  logic             st_done,

    output logic             flush,
    output logic [XLEN-1:0]  flush_pc,

    output logic [TAG_W:0]   count
);

    localparam int unsigned CNT_W = TAG_W + 1;

    localparam logic [1:0] KindReg    = 2'b00;
    localparam logic [1:0] KindStore  = 2'b01;
    localparam logic [1:0] KindBranch = 2'b10;
    localparam logic [1:0] KindJump   = 2'b11;

    typedef enum logic [0:0] {StRun, StStWait} state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Per-entry state
    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] rdy_q, rdy_d;
    logic [DEPTH-1:0] taken_q, taken_d;
    logic [1:0]       kind_q   [DEPTH];
    logic [1:0]       kind_d   [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [4:0]       rd_d     [DEPTH];
    logic [XLEN-1:0]  pc_q     [DEPTH];
    logic [XLEN-1:0]  pc_d     [DEPTH];
    logic [XLEN-1:0]  value_q  [DEPTH];
    logic [XLEN-1:0]  value_d  [DEPTH];
    logic [XLEN-1:0]  target_q [DEPTH];
    logic [XLEN-1:0]  target_d [DEPTH];

    // Registered outputs
    logic             commit_valid_q, commit_valid_d;
    logic [4:0]       commit_rd_q, commit_rd_d;
    logic [XLEN-1:0]  commit_value_q, commit_value_d;
    logic [TAG_W-1:0] commit_tag_q, commit_tag_d;
    logic             st_commit_valid_q, st_commit_valid_d;
    logic [TAG_W-1:0] st_commit_tag_q, st_commit_tag_d;
    logic             flush_q, flush_d;
    logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

    logic             full;
    logic             head_busy;
    logic             head_rdy;
    logic [1:0]       head_kind;
    logic             head_redirect;
    logic             alloc_fire;
    logic             retire;
    logic             do_flush;

    assign full          = (count_q == CNT_W'(DEPTH));
    assign head_busy     = busy_q[head_q];
    assign head_rdy      = rdy_q[head_q];
    assign head_kind     = kind_q[head_q];
    assign head_redirect = (head_kind == KindJump) ||
                           ((head_kind == KindBranch) && taken_q[head_q]);

    // Allocation stalls while the head is about to redirect so no new entry is lost to the flush.
    assign alloc_ready = !full && !(head_busy && head_rdy && head_redirect) && (state_q == StRun);
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign alloc_tag   = tail_q;

    // Commit FSM and output decode
    always_comb begin
        state_d           = state_q;
        retire            = 1'b0;
        do_flush          = 1'b0;
        commit_valid_d    = 1'b0;
        commit_rd_d       = '0;
        commit_value_d    = '0;
        commit_tag_d      = '0;
        st_commit_valid_d = 1'b0;
        st_commit_tag_d   = '0;
        flush_d           = 1'b0;
        flush_pc_d        = '0;

        unique case (state_q)
            StRun: begin
                if (head_busy && head_rdy) begin
                    unique case (head_kind)
                        KindReg: begin
                            commit_valid_d = 1'b1;
                            commit_rd_d    = rd_q[head_q];
                            commit_value_d = value_q[head_q];
                            commit_tag_d   = head_q;
                            retire         = 1'b1;
                        end
                        KindBranch: begin
                            commit_valid_d = 1'b1;
                            commit_value_d = value_q[head_q];
                            commit_tag_d   = head_q;
                            retire         = 1'b1;
                            if (taken_q[head_q]) begin
                                flush_d    = 1'b1;
                                flush_pc_d = target_q[head_q];
                                do_flush   = 1'b1;
                            end
                        end
                        KindJump: begin
                            commit_valid_d = 1'b1;
                            commit_rd_d    = rd_q[head_q];
                            commit_value_d = pc_q[head_q] + XLEN'(4);
                            commit_tag_d   = head_q;
                            retire         = 1'b1;
                            flush_d        = 1'b1;
                            flush_pc_d     = target_q[head_q];
                            do_flush       = 1'b1;
                        end
                        KindStore: begin
                            st_commit_valid_d = 1'b1;
                            st_commit_tag_d   = head_q;
                            state_d           = StStWait;
                        end
                        default: ;
                    endcase
                end
            end
            StStWait: begin
                if (st_done) begin
                    commit_valid_d = 1'b1;
                    commit_value_d = value_q[head_q];
                    commit_tag_d   = head_q;
                    retire         = 1'b1;
                    state_d        = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Entry array and pointer next-state
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        busy_d   = busy_q;
        rdy_d    = rdy_q;
        taken_d  = taken_q;
        kind_d   = kind_q;
        rd_d     = rd_q;
        pc_d     = pc_q;
        value_d  = value_q;
        target_d = target_q;

        // wb1 is applied last so it wins a same-tag collision with wb0.
        if (wb0_valid && busy_q[wb0_tag]) begin
            value_d[wb0_tag] = wb0_value;
            rdy_d[wb0_tag]   = 1'b1;
        end
        if (wb1_valid && busy_q[wb1_tag]) begin
            value_d[wb1_tag] = wb1_value;
            rdy_d[wb1_tag]   = 1'b1;
        end
        if (br_valid && busy_q[br_tag]) begin
            taken_d[br_tag]  = br_taken;
            target_d[br_tag] = br_target;
            rdy_d[br_tag]    = 1'b1;
        end

        if (retire) begin
            busy_d[head_q] = 1'b0;
            head_d         = head_q + TAG_W'(1);
        end

        // Link value pc+4 is preloaded so a jump needs no data writeback.
        if (alloc_fire) begin
            busy_d[tail_q]   = 1'b1;
            rdy_d[tail_q]    = 1'b0;
            taken_d[tail_q]  = 1'b0;
            kind_d[tail_q]   = alloc_kind;
            rd_d[tail_q]     = alloc_rd;
            pc_d[tail_q]     = alloc_pc;
            value_d[tail_q]  = alloc_pc + XLEN'(4);
            target_d[tail_q] = '0;
            tail_d           = tail_q + TAG_W'(1);
        end

        unique case ({alloc_fire, retire})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (do_flush) begin
            busy_d  = '0;
            rdy_d   = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Operand query
    always_comb begin
        q_ready = busy_q[q_tag] & rdy_q[q_tag];
        q_value = value_q[q_tag];
`ifdef ROB_BYPASS_EN
        if (wb1_valid && (wb1_tag == q_tag) && busy_q[q_tag]) begin
            q_ready = 1'b1;
            q_value = wb1_value;
        end else if (wb0_valid && (wb0_tag == q_tag) && busy_q[q_tag]) begin
            q_ready = 1'b1;
            q_value = wb0_value;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q           <= StRun;
            head_q            <= '0;
            tail_q            <= '0;
            count_q           <= '0;
            busy_q            <= '0;
            rdy_q             <= '0;
            taken_q           <= '0;
            commit_valid_q    <= 1'b0;
            commit_rd_q       <= '0;
            commit_value_q    <= '0;
            commit_tag_q      <= '0;
            st_commit_valid_q <= 1'b0;
            st_commit_tag_q   <= '0;
            flush_q           <= 1'b0;
            flush_pc_q        <= '0;
        end else begin
            state_q           <= state_d;
            head_q            <= head_d;
            tail_q            <= tail_d;
            count_q           <= count_d;
            busy_q            <= busy_d;
            rdy_q             <= rdy_d;
            taken_q           <= taken_d;
            commit_valid_q    <= commit_valid_d;
            commit_rd_q       <= commit_rd_d;
            commit_value_q    <= commit_value_d;
            commit_tag_q      <= commit_tag_d;
            st_commit_valid_q <= st_commit_valid_d;
            st_commit_tag_q   <= st_commit_tag_d;
            flush_q           <= flush_d;
            flush_pc_q        <= flush_pc_d;
        end
    end

    // Payload storage is qualified by busy/ready and needs no reset.
    always_ff @(posedge clk) begin
        kind_q   <= kind_d;
        rd_q     <= rd_d;
        pc_q     <= pc_d;
        value_q  <= value_d;
        target_q <= target_d;
    end

    assign commit_valid    = commit_valid_q;
    assign commit_rd       = commit_rd_q;
    assign commit_value    = commit_value_q;
    assign commit_tag      = commit_tag_q;
    assign st_commit_valid = st_commit_valid_q;
    assign st_commit_tag   = st_commit_tag_q;
    assign flush           = flush_q;
    assign flush_pc        = flush_pc_q;
    assign count           = count_q;

endmodule

// File: tb/tb_rob_queue.sv
// tb_rob_queue: directed self-checking bench for rob_queue; a negedge monitor checks every retire
// against an in-order queue of hand-computed expectations.
module tb_rob_queue;

    localparam logic [1:0] KReg    = 2'b00;
    localparam logic [1:0] KStore  = 2'b01;
    localparam logic [1:0] KBranch = 2'b10;
    localparam logic [1:0] KJump   = 2'b11;

`ifdef ROB_BYPASS_EN
    localparam logic BypassExp = 1'b1;
`else
    localparam logic BypassExp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_valid = 1'b0;
    logic        alloc_ready;
    logic [1:0]  alloc_kind = 2'b00;
    logic [4:0]  alloc_rd = '0;
    logic [31:0] alloc_pc = '0;
    logic [2:0]  alloc_tag;
    logic        wb0_valid = 1'b0;
    logic [2:0]  wb0_tag = '0;
    logic [31:0] wb0_value = '0;
    logic        wb1_valid = 1'b0;
    logic [2:0]  wb1_tag = '0;
    logic [31:0] wb1_value = '0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_tag = '0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic [2:0]  q_tag = '0;
    logic        q_ready;
    logic [31:0] q_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_tag;
    logic        st_commit_valid;
    logic [2:0]  st_commit_tag;
    logic        st_done = 1'b0;
    logic        flush;
    logic [31:0] flush_pc;
    logic [3:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        logic        chk_val;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    rob_queue #(.DEPTH(8), .TAG_W(3), .XLEN(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_valid     (alloc_valid),
        .alloc_ready     (alloc_ready),
        .alloc_kind      (alloc_kind),
        .alloc_rd        (alloc_rd),
        .alloc_pc        (alloc_pc),
        .alloc_tag       (alloc_tag),
        .wb0_valid       (wb0_valid),
        .wb0_tag         (wb0_tag),
        .wb0_value       (wb0_value),
        .wb1_valid       (wb1_valid),
        .wb1_tag         (wb1_tag),
        .wb1_value       (wb1_value),
        .br_valid        (br_valid),
        .br_tag          (br_tag),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .q_tag           (q_tag),
        .q_ready         (q_ready),
        .q_value         (q_value),
        .commit_valid    (commit_valid),
        .commit_rd       (commit_rd),
        .commit_value    (commit_value),
        .commit_tag      (commit_tag),
        .st_commit_valid (st_commit_valid),
        .st_commit_tag   (st_commit_tag),
        .st_done         (st_done),
        .flush           (flush),
        .flush_pc        (flush_pc),
        .count           (count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] val, input logic chk_val,
                            input logic fl, input logic [31:0] fpc);
        exp_t e;
        e.rd      = rd;
        e.val     = val;
        e.chk_val = chk_val;
        e.fl      = fl;
        e.fpc     = fpc;
        exp_q.push_back(e);
    endtask

    task automatic do_alloc(input logic [1:0] kind, input logic [4:0] rd, input logic [31:0] pc);
        alloc_valid = 1'b1;
        alloc_kind  = kind;
        alloc_rd    = rd;
        alloc_pc    = pc;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic do_wb0(input logic [2:0] tag, input logic [31:0] val);
        wb0_valid = 1'b1;
        wb0_tag   = tag;
        wb0_value = val;
        tick();
        wb0_valid = 1'b0;
    endtask

    task automatic do_br(input logic [2:0] tag, input logic taken, input logic [31:0] target);
        br_valid  = 1'b1;
        br_tag    = tag;
        br_taken  = taken;
        br_target = target;
        tick();
        br_valid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'(0));
    endtask

    // Retire monitor
    always @(negedge clk) begin
        if (commit_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_commit", 64'(commit_valid), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("commit_rd", 64'(commit_rd), 64'(mon_e.rd));
                if (mon_e.chk_val) check_eq("commit_value", 64'(commit_value), 64'(mon_e.val));
                check_eq("commit_flush", 64'(flush), 64'(mon_e.fl));
                if (mon_e.fl) check_eq("commit_flush_pc", 64'(flush_pc), 64'(mon_e.fpc));
            end
        end else if (flush) begin
            check_eq("stray_flush", 64'(flush), 64'(0));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick();
        tick();
        check_eq("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check_eq("rst_count", 64'(count), 64'(0));
        check_eq("rst_alloc_tag", 64'(alloc_tag), 64'(0));
        check_eq("rst_commit_valid", 64'(commit_valid), 64'(0));
        check_eq("rst_st_commit", 64'(st_commit_valid), 64'(0));
        check_eq("rst_flush", 64'(flush), 64'(0));
        check_eq("rst_q_ready", 64'(q_ready), 64'(0));
        rst = 1'b1;

        // Fill, refuse when full, then drain in order
        for (int i = 0; i < 8; i++) do_alloc(KReg, 5'(i + 1), 32'h1000 + 32'(4 * i));
        check_eq("full_count", 64'(count), 64'(8));
        check_eq("full_alloc_ready", 64'(alloc_ready), 64'(0));
        check_eq("full_alloc_tag", 64'(alloc_tag), 64'(0));
        do_alloc(KReg, 5'd9, 32'h2000);
        check_eq("full_refused", 64'(count), 64'(8));
        for (int i = 0; i < 8; i++) push_exp(5'(i + 1), 32'h100 + 32'(i), 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 8; i++) do_wb0(3'(i), 32'h100 + 32'(i));
        wait_drain(20);
        tick();
        check_eq("fill_count_empty", 64'(count), 64'(0));
        check_eq("fill_tail_wrap", 64'(alloc_tag), 64'(0));
        check_eq("fill_alloc_ready", 64'(alloc_ready), 64'(1));

        // Out-of-order writeback, in-order retire
        do_alloc(KReg, 5'd1, 32'h10);
        do_alloc(KReg, 5'd2, 32'h14);
        do_alloc(KReg, 5'd3, 32'h18);
        push_exp(5'd1, 32'h10, 1'b1, 1'b0, 32'h0);
        push_exp(5'd2, 32'h20, 1'b1, 1'b0, 32'h0);
        push_exp(5'd3, 32'h30, 1'b1, 1'b0, 32'h0);
        do_wb0(3'd2, 32'h30);
        wb1_valid = 1'b1; wb1_tag = 3'd1; wb1_value = 32'h20;
        tick();
        wb1_valid = 1'b0;
        check_eq("ooo_no_early_commit", 64'(count), 64'(3));
        do_wb0(3'd0, 32'h10);
        wait_drain(10);

        // Store handshake
        do_reset();
        do_alloc(KStore, 5'd0, 32'h200);
        do_wb0(3'd0, 32'h1234);
        check_eq("st_not_yet", 64'(st_commit_valid), 64'(0));
        tick();
        check_eq("st_commit_valid", 64'(st_commit_valid), 64'(1));
        check_eq("st_commit_tag", 64'(st_commit_tag), 64'(0));
        tick();
        check_eq("st_pulse_one", 64'(st_commit_valid), 64'(0));
        repeat (4) tick();
        check_eq("st_wait_count", 64'(count), 64'(1));
        check_eq("st_wait_alloc_ready", 64'(alloc_ready), 64'(0));
        push_exp(5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        st_done = 1'b1;
        tick();
        st_done = 1'b0;
        check_eq("st_retire", 64'(commit_valid), 64'(1));
        check_eq("st_count", 64'(count), 64'(0));
        check_eq("st_back_run", 64'(alloc_ready), 64'(1));

        // Reset during store wait, then stray st_done in RUN must be ignored
        do_alloc(KStore, 5'd0, 32'h300);
        do_wb0(3'd1, 32'h55);
        tick();
        check_eq("st2_commit_tag", 64'(st_commit_tag), 64'(1));
        do_reset();
        check_eq("abort_count", 64'(count), 64'(0));
        check_eq("abort_alloc_ready", 64'(alloc_ready), 64'(1));
        st_done = 1'b1;
        tick();
        st_done = 1'b0;
        repeat (2) tick();

        // Mispredict flush
        do_alloc(KBranch, 5'd0, 32'h20);
        do_alloc(KReg, 5'd4, 32'h24);
        do_alloc(KReg, 5'd5, 32'h28);
        do_alloc(KReg, 5'd6, 32'h2c);
        push_exp(5'd0, 32'h0, 1'b0, 1'b1, 32'h100);
        do_br(3'd0, 1'b1, 32'h100);
        check_eq("mp_flush_early", 64'(flush), 64'(0));
        check_eq("mp_alloc_block", 64'(alloc_ready), 64'(0));
        wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_value = 32'h99;
        tick();
        wb0_valid = 1'b0;
        check_eq("mp_flush", 64'(flush), 64'(1));
        check_eq("mp_flush_pc", 64'(flush_pc), 64'(32'h100));
        check_eq("mp_count", 64'(count), 64'(0));
        do_wb0(3'd2, 32'haa);
        check_eq("mp_flush_pulse", 64'(flush), 64'(0));
        check_eq("mp_alloc_ready", 64'(alloc_ready), 64'(1));
        check_eq("mp_alloc_tag", 64'(alloc_tag), 64'(0));
        q_tag = 3'd2;
        #1;
        check_eq("mp_wb_ignored", 64'(q_ready), 64'(0));
        q_tag = 3'd0;
        repeat (4) tick();

        // Not-taken branch retires without redirect
        do_alloc(KBranch, 5'd0, 32'h60);
        do_alloc(KReg, 5'd5, 32'h64);
        push_exp(5'd0, 32'h0, 1'b0, 1'b0, 32'h0);
        push_exp(5'd5, 32'h77, 1'b1, 1'b0, 32'h0);
        do_br(3'd0, 1'b0, 32'h300);
        do_wb0(3'd1, 32'h77);
        wait_drain(10);

        // Jump with link register
        do_alloc(KJump, 5'd1, 32'h40);
        push_exp(5'd1, 32'h44, 1'b1, 1'b1, 32'h80);
        do_br(3'd2, 1'b1, 32'h80);
        tick();
        check_eq("jmp_commit_value", 64'(commit_value), 64'(32'h44));
        check_eq("jmp_flush_pc", 64'(flush_pc), 64'(32'h80));
        check_eq("jmp_commit_tag", 64'(commit_tag), 64'(2));
        tick();
        check_eq("jmp_count", 64'(count), 64'(0));
        check_eq("jmp_alloc_tag", 64'(alloc_tag), 64'(0));

        // Query forwarding
        do_alloc(KReg, 5'd1, 32'h500);
        do_alloc(KReg, 5'd2, 32'h504);
        do_alloc(KReg, 5'd3, 32'h508);
        push_exp(5'd1, 32'h10, 1'b1, 1'b0, 32'h0);
        push_exp(5'd2, 32'h22, 1'b1, 1'b0, 32'h0);
        push_exp(5'd3, 32'h55, 1'b1, 1'b0, 32'h0);
        q_tag = 3'd2;
        wb0_valid = 1'b1; wb0_tag = 3'd2; wb0_value = 32'h55;
        #1;
        check_eq("byp_same_cycle", 64'(q_ready), 64'(BypassExp));
        tick();
        wb0_valid = 1'b0;
        check_eq("byp_next_ready", 64'(q_ready), 64'(1));
        check_eq("byp_next_value", 64'(q_value), 64'(32'h55));
        q_tag = 3'd1;
        wb0_valid = 1'b1; wb0_tag = 3'd1; wb0_value = 32'h11;
        wb1_valid = 1'b1; wb1_tag = 3'd1; wb1_value = 32'h22;
        #1;
        check_eq("byp_dual_same_cycle", 64'(q_ready), 64'(BypassExp));
        tick();
        wb0_valid = 1'b0;
        wb1_valid = 1'b0;
        check_eq("wb1_wins", 64'(q_value), 64'(32'h22));
        q_tag = 3'd0;
        do_wb0(3'd0, 32'h10);
        wait_drain(10);
        tick();
        check_eq("final_count", 64'(count), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
